// File: rtl/fp_addsub_pkg.sv
// Shared types and width helpers for the sequential FP add/subtract unit.
package fp_addsub_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLASSIFY,
        ALIGN,
        ADD,
        NORM,
        ROUND,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        CLS_ZERO,
        CLS_NORM,
        CLS_INF,
        CLS_NAN
    } fp_class_e;

    // Working significand: carry + hidden + mantissa + guard/round/sticky.
    function automatic int unsigned sig_width(input int unsigned ment_width);
        return ment_width + 5;
    endfunction

    // Beyond this exponent difference the smaller operand is pure sticky.
    function automatic int unsigned align_limit(input int unsigned ment_width);
        return ment_width + 3;
    endfunction

    // Single-precision defaults.
    localparam int unsigned DEF_EXPO_WIDTH  = 8;
    localparam int unsigned DEF_MENT_WIDTH  = 23;
    localparam int unsigned DEF_SIG_WIDTH   = sig_width(DEF_MENT_WIDTH);
    localparam int unsigned DEF_ALIGN_LIMIT = align_limit(DEF_MENT_WIDTH);
    localparam logic [DEF_EXPO_WIDTH-1:0] DEF_EXP_ONES = '1;
    localparam logic [31:0] DEF_QNAN = 32'h7FC0_0000;

endpackage

// File: rtl/fp_round_rne.sv
// Combinational round-to-nearest-even on a normalised mantissa plus G/R/S bits.
module fp_round_rne #(
    parameter int unsigned EXPO_WIDTH = 8,
    parameter int unsigned MENT_WIDTH = 23
) (
    input  logic [MENT_WIDTH-1:0] mant,
    input  logic [2:0]            grs,
    input  logic [EXPO_WIDTH:0]   expo,
    output logic [MENT_WIDTH-1:0] mant_rnd,
    output logic [EXPO_WIDTH-1:0] expo_rnd,
    output logic                  ovf
);

    localparam int unsigned SUM_W = MENT_WIDTH + 1;
    localparam int unsigned EXP_W = EXPO_WIDTH + 1;
    localparam logic [EXP_W-1:0] EXP_MAX = {1'b0, {EXPO_WIDTH{1'b1}}};

    logic             round_up;
    logic [SUM_W-1:0] sum;
    logic [EXP_W-1:0] exp_sum;

    // Increment on guard when above half, or exactly half with an odd LSB.
    always_comb begin
        round_up = grs[2] & (grs[1] | grs[0] | mant[0]);
        sum      = {1'b0, mant} + SUM_W'(round_up);
        mant_rnd = sum[MENT_WIDTH-1:0];
        exp_sum  = expo + EXP_W'(sum[MENT_WIDTH]);
        expo_rnd = exp_sum[EXPO_WIDTH-1:0];
        ovf      = (exp_sum >= EXP_MAX);
    end

endmodule

// File: rtl/fp_addsub_seq_unit.sv
// Multi-cycle IEEE-754 add/subtract with FTZ, RNE rounding and valid/ready handshakes.
module fp_addsub_seq_unit
    import fp_addsub_pkg::*;
#(
    parameter int unsigned EXPO_WIDTH = 8,
    parameter int unsigned MENT_WIDTH = 23,
    parameter int unsigned DATA_WIDTH = 1 + EXPO_WIDTH + MENT_WIDTH
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  in_valid_in,
    output logic                  in_ready_out,
    input  logic                  op_in,
    input  logic [DATA_WIDTH-1:0] floating1_in,
    input  logic [DATA_WIDTH-1:0] floating2_in,
    output logic                  out_valid_out,
    input  logic                  out_ready_in,
    output logic [DATA_WIDTH-1:0] result_out,
    output logic                  overflow_out,
    output logic                  underflow_out,
    output logic                  invalid_out,
    output logic                  busy_out
);

    localparam int unsigned E  = EXPO_WIDTH;
    localparam int unsigned W  = MENT_WIDTH;
    localparam int unsigned DW = DATA_WIDTH;
    localparam int unsigned SW = sig_width(W);
    localparam int unsigned EW = E + 1;
    localparam int unsigned ALIGN_LIMIT = align_limit(W);
    localparam logic [E-1:0]  EXP_ONES = '1;
    localparam logic [DW-1:0] QNAN = {1'b0, EXP_ONES, 1'b1, {(W-1){1'b0}}};

    if (DATA_WIDTH != 1 + EXPO_WIDTH + MENT_WIDTH) begin : g_bad_width
        $error("DATA_WIDTH must equal 1+EXPO_WIDTH+MENT_WIDTH");
    end

    state_e         state_q, state_d;
    logic [DW-1:0]  op_a_q, op_a_d, op_b_q, op_b_d;
    logic           sign_r_q, sign_r_d;
    logic           eff_sub_q, eff_sub_d;
    logic           zero_neg_q, zero_neg_d;
    logic [EW-1:0]  exp_r_q, exp_r_d;
    logic [SW-1:0]  sig_a_q, sig_a_d, sig_b_q, sig_b_d;
    logic [E-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]  result_q, result_d;
    logic           ovf_q, ovf_d, unf_q, unf_d, inv_q, inv_d;
    logic           out_valid_q, out_valid_d;
    logic           in_ready_q, in_ready_d;
    logic           busy_q, busy_d;

    logic           sign_a, sign_b;
    logic [E-1:0]   exp_a, exp_b, big_exp, small_exp;
    logic [W-1:0]   mant_a, mant_b, big_mant, small_mant;
    fp_class_e      cls_a, cls_b;
    logic           a_zero, b_zero, big_zero, small_zero, b_gt;
    logic [DW-2:0]  mag_a, mag_b;

    logic [W-1:0]   mant_rnd;
    logic [E-1:0]   exp_rnd;
    logic           ovf_rnd;

    function automatic fp_class_e classify(input logic [E-1:0] e, input logic [W-1:0] m);
        fp_class_e c;
        c = CLS_NORM;
        if (e == '0)
            c = CLS_ZERO;
        else if (e == EXP_ONES)
            c = (m == '0) ? CLS_INF : CLS_NAN;
        return c;
    endfunction

    fp_round_rne #(
        .EXPO_WIDTH (E),
        .MENT_WIDTH (W)
    ) u_round (
        .mant     (sig_a_q[SW-3:3]),
        .grs      (sig_a_q[2:0]),
        .expo     (exp_r_q),
        .mant_rnd (mant_rnd),
        .expo_rnd (exp_rnd),
        .ovf      (ovf_rnd)
    );

    // Operand field decode, class and magnitude ordering (subnormals read as zero).
    always_comb begin
        sign_a     = op_a_q[DW-1];
        sign_b     = op_b_q[DW-1];
        exp_a      = op_a_q[DW-2 -: E];
        exp_b      = op_b_q[DW-2 -: E];
        mant_a     = op_a_q[W-1:0];
        mant_b     = op_b_q[W-1:0];
        cls_a      = classify(exp_a, mant_a);
        cls_b      = classify(exp_b, mant_b);
        a_zero     = (cls_a == CLS_ZERO);
        b_zero     = (cls_b == CLS_ZERO);
        mag_a      = a_zero ? '0 : op_a_q[DW-2:0];
        mag_b      = b_zero ? '0 : op_b_q[DW-2:0];
        b_gt       = (mag_b > mag_a);
        big_exp    = b_gt ? exp_b  : exp_a;
        big_mant   = b_gt ? mant_b : mant_a;
        big_zero   = b_gt ? b_zero : a_zero;
        small_exp  = b_gt ? exp_a  : exp_b;
        small_mant = b_gt ? mant_a : mant_b;
        small_zero = b_gt ? a_zero : b_zero;
    end

    // Next-state and datapath update for every FSM step.
    always_comb begin
        state_d    = state_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        sign_r_d   = sign_r_q;
        eff_sub_d  = eff_sub_q;
        zero_neg_d = zero_neg_q;
        exp_r_d    = exp_r_q;
        sig_a_d    = sig_a_q;
        sig_b_d    = sig_b_q;
        cnt_d      = cnt_q;
        result_d   = result_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        inv_d      = inv_q;

        case (state_q)
            IDLE: begin
                if (in_valid_in && in_ready_q) begin
                    op_a_d   = floating1_in;
                    op_b_d   = {floating2_in[DW-1] ^ op_in, floating2_in[DW-2:0]};
                    result_d = '0;
                    ovf_d    = 1'b0;
                    unf_d    = 1'b0;
                    inv_d    = 1'b0;
                    state_d  = CLASSIFY;
                end
            end
            CLASSIFY: begin
                if (cls_a == CLS_NAN || cls_b == CLS_NAN ||
                    (cls_a == CLS_INF && cls_b == CLS_INF && sign_a != sign_b)) begin
                    result_d = QNAN;
                    inv_d    = 1'b1;
                    state_d  = DONE;
                end else if (cls_a == CLS_INF) begin
                    result_d = op_a_q;
                    state_d  = DONE;
                end else if (cls_b == CLS_INF) begin
                    result_d = op_b_q;
                    state_d  = DONE;
                end else begin
                    sign_r_d   = b_gt ? sign_b : sign_a;
                    eff_sub_d  = sign_a ^ sign_b;
                    zero_neg_d = a_zero & b_zero & sign_a & sign_b;
                    exp_r_d    = {1'b0, big_exp};
                    sig_a_d    = big_zero   ? '0 : {2'b01, big_mant, 3'b000};
                    sig_b_d    = small_zero ? '0 : {2'b01, small_mant, 3'b000};
                    cnt_d      = small_zero ? '0 : big_exp - small_exp;
                    state_d    = ALIGN;
                end
            end
            ALIGN: begin
                if (cnt_q == '0) begin
                    state_d = ADD;
                end else if (32'(cnt_q) > ALIGN_LIMIT) begin
                    sig_b_d = SW'(|sig_b_q);
                    cnt_d   = '0;
                    state_d = ADD;
                end else begin
                    sig_b_d = {1'b0, sig_b_q[SW-1:2], |sig_b_q[1:0]};
                    cnt_d   = cnt_q - E'(1);
                    if (cnt_q == E'(1))
                        state_d = ADD;
                end
            end
            ADD: begin
                sig_a_d = eff_sub_q ? (sig_a_q - sig_b_q) : (sig_a_q + sig_b_q);
                state_d = NORM;
            end
            NORM: begin
                if (sig_a_q[SW-1]) begin
                    sig_a_d = {1'b0, sig_a_q[SW-1:2], |sig_a_q[1:0]};
                    exp_r_d = exp_r_q + EW'(1);
                    state_d = ROUND;
                end else if (sig_a_q == '0) begin
                    result_d = {zero_neg_q, {(DW-1){1'b0}}};
                    state_d  = DONE;
                end else if (sig_a_q[SW-2]) begin
                    state_d = ROUND;
                end else begin
                    sig_a_d = {sig_a_q[SW-2:0], 1'b0};
                    exp_r_d = exp_r_q - EW'(1);
                    if (exp_r_q == EW'(1)) begin
                        result_d = {sign_r_q, {(DW-1){1'b0}}};
                        unf_d    = 1'b1;
                        state_d  = DONE;
                    end
                end
            end
            ROUND: begin
                if (ovf_rnd) begin
                    result_d = {sign_r_q, EXP_ONES, {W{1'b0}}};
                    ovf_d    = 1'b1;
                end else begin
                    result_d = {sign_r_q, exp_rnd, mant_rnd};
                end
                state_d = DONE;
            end
            DONE: begin
                if (out_ready_in)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        out_valid_d = (state_d == DONE);
        in_ready_d  = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
    end

    // State, datapath and registered outputs; reset discards any operation in flight.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= IDLE;
            op_a_q      <= '0;
            op_b_q      <= '0;
            sign_r_q    <= 1'b0;
            eff_sub_q   <= 1'b0;
            zero_neg_q  <= 1'b0;
            exp_r_q     <= '0;
            sig_a_q     <= '0;
            sig_b_q     <= '0;
            cnt_q       <= '0;
            result_q    <= '0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
            inv_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            sign_r_q    <= sign_r_d;
            eff_sub_q   <= eff_sub_d;
            zero_neg_q  <= zero_neg_d;
            exp_r_q     <= exp_r_d;
            sig_a_q     <= sig_a_d;
            sig_b_q     <= sig_b_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
            inv_q       <= inv_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready_out  = in_ready_q;
    assign out_valid_out = out_valid_q;
    assign result_out    = result_q;
    assign overflow_out  = ovf_q;
    assign underflow_out = unf_q;
    assign invalid_out   = inv_q;
    assign busy_out      = busy_q;

endmodule

// File: tb/tb_fp_addsub_seq_unit.sv
// Directed bench for fp_addsub_seq_unit in single precision.
module tb_fp_addsub_seq_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        op;
    logic [31:0] fa, fb;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        overflow, underflow, invalid, busy;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        o;
        logic [31:0] r;
        logic [2:0]  f;   // {overflow, underflow, invalid}
        int          lat; // 0 = latency not checked
    } vec_t;

    vec_t vecs[$];

    fp_addsub_seq_unit dut (
        .clk_in        (clk),
        .rst_in        (rst),
        .in_valid_in   (in_valid),
        .in_ready_out  (in_ready),
        .op_in         (op),
        .floating1_in  (fa),
        .floating2_in  (fb),
        .out_valid_out (out_valid),
        .out_ready_in  (out_ready),
        .result_out    (result),
        .overflow_out  (overflow),
        .underflow_out (underflow),
        .invalid_out   (invalid),
        .busy_out      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Present operands until accepted; returns #1 after the transfer edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic o);
        logic rdy;
        int   k;
        fa = a; fb = b; op = o; in_valid = 1'b1;
        k = 0;
        rdy = 1'b0;
        while (!rdy && k < 100) begin
            rdy = in_ready;
            @(posedge clk); #1;
            k++;
        end
        in_valid = 1'b0;
        if (!rdy) check("send_timeout", 32'(in_ready), 32'd1);
    endtask

    // Count edges from the transfer edge (edge 1) until out_valid is seen.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) check("valid_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic accept();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic o,
                          output logic [31:0] res, output logic [2:0] flg, output int lat);
        send(a, b, o);
        wait_valid(lat);
        res = result;
        flg = {overflow, underflow, invalid};
        accept();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] res;
        logic [2:0]  flg;
        int          lat;
        logic        seen;

        rst = 1'b1; in_valid = 1'b0; op = 1'b0; fa = '0; fb = '0; out_ready = 1'b0;

        vecs.push_back('{32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 3'b000, 6});
        vecs.push_back('{32'h3FC0_0000, 32'h3FC0_0000, 1'b1, 32'h0000_0000, 3'b000, 0});
        vecs.push_back('{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000, 3'b000, 0});
        vecs.push_back('{32'h4040_0000, 32'h3080_0000, 1'b0, 32'h4040_0000, 3'b000, 6});
        vecs.push_back('{32'h3F80_0000, 32'h3380_0000, 1'b0, 32'h3F80_0000, 3'b000, 29});
        vecs.push_back('{32'h3F80_0000, 32'h33C0_0000, 1'b0, 32'h3F80_0001, 3'b000, 29});
        vecs.push_back('{32'h3F80_0001, 32'h3380_0000, 1'b0, 32'h3F80_0002, 3'b000, 0});
        vecs.push_back('{32'h7F80_0000, 32'hFF80_0000, 1'b0, 32'h7FC0_0000, 3'b001, 2});
        vecs.push_back('{32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, 3'b100, 6});
        vecs.push_back('{32'h4000_0000, 32'h3F80_0000, 1'b1, 32'h3F80_0000, 3'b000, 7});
        vecs.push_back('{32'h3F80_0000, 32'h4000_0000, 1'b1, 32'hBF80_0000, 3'b000, 7});
        vecs.push_back('{32'h0080_0001, 32'h0080_0000, 1'b1, 32'h0000_0000, 3'b010, 0});
        vecs.push_back('{32'h7FC0_0001, 32'h3F80_0000, 1'b0, 32'h7FC0_0000, 3'b001, 2});
        vecs.push_back('{32'hFF80_0000, 32'h3F80_0000, 1'b0, 32'hFF80_0000, 3'b000, 2});
        vecs.push_back('{32'h0000_0001, 32'h3F80_0000, 1'b0, 32'h3F80_0000, 3'b000, 6});
        vecs.push_back('{32'h7F80_0000, 32'h7F80_0000, 1'b1, 32'h7FC0_0000, 3'b001, 2});

        // Reset state.
        @(posedge clk); @(posedge clk); #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_flags", 32'({overflow, underflow, invalid}), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Directed vectors.
        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].o, res, flg, lat);
            check($sformatf("v%0d_result", i), res, vecs[i].r);
            check($sformatf("v%0d_flags", i), 32'(flg), 32'(vecs[i].f));
            if (vecs[i].lat != 0)
                check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
        end

        // Backpressure: result held, input ignored while DONE.
        send(32'h3F80_0000, 32'h3F80_0000, 1'b0);
        wait_valid(lat);
        check("bp_latency", 32'(lat), 32'd6);
        fa = 32'h4040_0000; fb = 32'h4040_0000; op = 1'b0; in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check($sformatf("bp_result_%0d", c), result, 32'h4000_0000);
            check($sformatf("bp_valid_%0d", c), 32'(out_valid), 32'd1);
            check($sformatf("bp_in_ready_%0d", c), 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        accept();
        check("bp_valid_fall", 32'(out_valid), 32'd0);
        check("bp_in_ready_rise", 32'(in_ready), 32'd1);
        seen = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            seen = seen | out_valid | busy;
        end
        check("bp_ignored_input", 32'(seen), 32'd0);

        // Reset in the middle of a long alignment.
        send(32'h3F80_0000, 32'h3B80_0000, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        check("mid_rst_result", result, 32'd0);
        check("mid_rst_flags", 32'({overflow, underflow, invalid}), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_ready_back", 32'(in_ready), 32'd1);
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            seen = seen | out_valid;
        end
        check("mid_rst_no_result", 32'(seen), 32'd0);

        // Unit still works after the aborted operation.
        run_op(32'h4000_0000, 32'h3F80_0000, 1'b0, res, flg, lat);
        check("after_rst_result", res, 32'h4040_0000);
        check("after_rst_flags", 32'(flg), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fp_addsub_seq_unit.md
Name: fp_addsub_seq_unit

Overview:
Multi-cycle, parametrised IEEE-754 add/subtract unit with an internal FSM, and valid/ready handshakes on both input and output. It covers all single-cycle control decisions: operand swap, sign selection, alignment shift and leading-one normalisation. It adds the following as sequential steps:
- subtraction mode
- special-value handling
- sticky-bit alignment
- round-to-nearest-even
- exception flags

It sits between operand issue logic and the result writeback stage of the FPU.

Parameters:
EXPO_WIDTH, 8, exponent field width (5 = half, 8 = single, 11 = double)
MENT_WIDTH, 23, stored mantissa field width
DATA_WIDTH, 1+EXPO_WIDTH+MENT_WIDTH, packed operand width; any other value is illegal

Ports:
clk_in  input  1  clock
rst_in  input  1  synchronous reset, active-high
in_valid_in  input  1  operands present
in_ready_out  output  1  unit can accept operands
op_in  input  1  0 = add, 1 = subtract (floating1 - floating2)
floating1_in  input  DATA_WIDTH  operand A
floating2_in  input  DATA_WIDTH  operand B
out_valid_out  output  1  result valid
out_ready_in  input  1  consumer accepts result
result_out  output  DATA_WIDTH  packed result
overflow_out  output  1  result rounded to infinity
underflow_out  output  1  nonzero result flushed to zero
invalid_out  output  1  NaN operand or inf - inf
busy_out  output  1  state != IDLE

Behaviour:
- One clock, clk_in; reset is synchronous and active-high on rst_in.
- Reset (also mid-operation): state -> IDLE; all outputs and flags 0; any in-flight operation is discarded. in_ready_out is 0 in the reset cycle and 1 from the next cycle.
- in_ready_out = (state == IDLE). Transfer occurs on in_valid_in & in_ready_out. On transfer, operands and op are registered; for subtract, B's sign is inverted.
- Subnormal inputs are treated as zero (flush-to-zero, FTZ). Working significand = hidden bit + mantissa + guard/round/sticky bits, plus 1 carry bit.
- FSM states: IDLE, CLASSIFY, ALIGN, ADD, NORM, ROUND, DONE.
- CLASSIFY (1 cycle):
  - Any NaN, or inf + (-inf) -> canonical qNaN (sign 0, exponent all ones, mantissa MSB 1), invalid_out = 1, go to DONE.
  - Any inf -> that inf, go to DONE.
  - Otherwise swap so A has the larger magnitude (exponent first, then mantissa). Result sign = sign of A. Load the shift counter with the exponent difference. Go to ALIGN.
- ALIGN:
  - Difference 0: 1 cycle.
  - Difference > MENT_WIDTH+3: B collapses to sticky-only in 1 cycle.
  - Otherwise: one right-shift of B per cycle, OR-ing shifted-out bits into sticky, until the counter reaches 0.
- ADD (1 cycle): add the significands when the effective signs match, otherwise subtract (A - B, never negative).
- NORM, one step per cycle:
  - Carry set: shift right (keep sticky), exponent +1, go to ROUND.
  - Significand zero: result +0 (-0 only if both operands were -0), go to DONE.
  - Hidden bit set: go to ROUND.
  - Otherwise: shift left, exponent -1. If the exponent reaches 0: result signed zero, underflow_out = 1, go to DONE.
- ROUND (1 cycle):
  - Round to nearest, ties to even, on the guard/round/sticky bits.
  - Mantissa overflow on rounding -> exponent +1.
  - Exponent all ones -> signed infinity, overflow_out = 1.
  - Go to DONE.
- Latency from the transfer edge to out_valid_out:
  - Finite operands: 4 + A + N cycles, where A = ALIGN cycles and N = NORM cycles.
  - Special operands: 2 cycles.
- DONE: out_valid_out = 1. result_out and flags are held stable until out_ready_in. On the handshake cycle, return to IDLE; out_valid_out falls the following cycle. No new operand is accepted in the same cycle. Flags are valid only while out_valid_out = 1.
- in_valid_in while busy is ignored; the upstream source must hold its operands.

Decomposition:
- Package fp_addsub_pkg:
  - state enum
  - localparams: working significand width (MENT_WIDTH+5), exponent all-ones, canonical qNaN, align collapse limit (MENT_WIDTH+3)
  - classify constants: ZERO/NORM/INF/NAN
- One sub-module, fp_round_rne: combinational RNE on {significand, guard/round/sticky bits, exponent}. It returns the rounded mantissa, the adjusted exponent and an overflow indication.

Test Plan:
- 1.0 + 1.0 (0x3F800000, 0x3F800000, op 0) -> 0x40000000, latency 6 (A = 1, N = 1), flags 0.
- 1.5 - 1.5 (0x3FC00000 twice, op 1) -> 0x00000000 (+0), flags 0. Same test with -0 + -0 (0x80000000 twice, op 0) -> 0x80000000.
- 3.0 + 2^-30 (0x40400000, 0x30800000) -> 0x40400000, A = 1 (collapse). Also 1.0 + 2^-24 (0x3F800000, 0x33800000): tie rounds to even -> 0x3F800000.
- Special operands:
  - inf + (-inf) (0x7F800000, 0xFF800000) -> 0x7FC00000, invalid_out = 1, latency 2.
  - 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000, overflow_out = 1.
- Backpressure and reset:
  - out_ready_in held low for 3 cycles in DONE: result_out stable, in_ready_out = 0, a new in_valid_in is ignored.
  - rst_in pulsed mid-ALIGN (operands 0x3F800000, 0x3B800000): next cycle state is IDLE, outputs 0, and no result is emitted.
